// File: rtl/sram_port_arbiter_pkg.sv
// Shared widths, word/address types and the round-robin pointer helper
// used by the SRAM port arbiter.
package sram_arb_pkg;

    localparam int NUM_PORTS_DEF = 4;
    localparam int ADDR_W_DEF    = 14;
    localparam int DATA_W_DEF    = 16;

    typedef logic [ADDR_W_DEF-1:0]            addr_t;
    typedef logic [DATA_W_DEF-1:0]            data_t;
    typedef logic [$clog2(NUM_PORTS_DEF)-1:0] port_idx_t;

    // Next search start after index idx; wraps explicitly so any n works.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts at the
// pointer and the pointer moves past the winner on every grant.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N = NUM_PORTS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] winner;
    logic [N-1:0]     gnt_raw;
    logic             found;
    int               cand;

    always_comb begin
        gnt_raw = '0;
        winner  = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr_q) + i) % N;
            for (int p = 0; p < N; p++) begin
                if (!found && (p == cand) && req[p]) begin
                    gnt_raw[p] = 1'b1;
                    winner     = IDX_W'(p);
                    found      = 1'b1;
                end
            end
        end
    end

    // Grants are suppressed for the whole time reset is held.
    assign gnt   = rst ? '0 : gnt_raw;
    assign ptr_d = found ? IDX_W'(rr_wrap_inc(32'(winner), N)) : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one simple-dual-port SRAM between NUM_PORTS requesters: independent
// round-robin write/read arbitration, tagged read return, write-first bypass.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        wr_req,
    input  logic [NUM_PORTS*ADDR_W-1:0] wr_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wr_data,
    output logic [NUM_PORTS-1:0]        wr_gnt,
    input  logic [NUM_PORTS-1:0]        rd_req,
    input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
    output logic [NUM_PORTS-1:0]        rd_gnt,
    output logic [NUM_PORTS-1:0]        rd_vld,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        sram_wr_en,
    output logic [ADDR_W-1:0]           sram_wr_addr,
    output logic [DATA_W-1:0]           sram_din,
    output logic                        sram_rd_en,
    output logic [ADDR_W-1:0]           sram_rd_addr,
    input  logic [DATA_W-1:0]           sram_dout
);

    logic [ADDR_W-1:0] wr_addr_terms [NUM_PORTS];
    logic [DATA_W-1:0] wr_data_terms [NUM_PORTS];
    logic [ADDR_W-1:0] rd_addr_terms [NUM_PORTS];

    logic [NUM_PORTS-1:0] rd_vld_q;
    logic                 byp_q;
    logic                 byp_d;
    logic [DATA_W-1:0]    byp_data_q;

    rr_arbiter #(.N(NUM_PORTS)) u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .gnt (wr_gnt)
    );

    rr_arbiter #(.N(NUM_PORTS)) u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req),
        .gnt (rd_gnt)
    );

    // Grants are one-hot, so an AND-OR mux selects the winner's slices.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign wr_addr_terms[gi] = {ADDR_W{wr_gnt[gi]}} & wr_addr[gi*ADDR_W +: ADDR_W];
        assign wr_data_terms[gi] = {DATA_W{wr_gnt[gi]}} & wr_data[gi*DATA_W +: DATA_W];
        assign rd_addr_terms[gi] = {ADDR_W{rd_gnt[gi]}} & rd_addr[gi*ADDR_W +: ADDR_W];
    end

    always_comb begin
        sram_wr_addr = '0;
        sram_din     = '0;
        sram_rd_addr = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            sram_wr_addr = sram_wr_addr | wr_addr_terms[p];
            sram_din     = sram_din     | wr_data_terms[p];
            sram_rd_addr = sram_rd_addr | rd_addr_terms[p];
        end
    end

    assign sram_wr_en = |wr_gnt;
    assign sram_rd_en = |rd_gnt;

    // The SRAM returns old data on a same-address collision; capture the new word instead.
    assign byp_d = sram_rd_en & sram_wr_en & (sram_rd_addr == sram_wr_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q   <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            rd_vld_q   <= rd_gnt;
            byp_q      <= byp_d;
            byp_data_q <= sram_din;
        end
    end

    assign rd_vld  = rd_vld_q;
    assign rd_data = byp_q ? byp_data_q : sram_dout;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and randomized bench for sram_port_arbiter against a simple
// behavioural model of round-robin arbitration and write-first memory.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int NP = 4;
    localparam int AW = 14;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    wr_req, rd_req, wr_gnt, rd_gnt, rd_vld;
    logic [NP*AW-1:0] wr_addr, rd_addr;
    logic [NP*DW-1:0] wr_data;
    logic [DW-1:0]    rd_data, sram_din, sram_dout;
    logic [AW-1:0]    sram_wr_addr, sram_rd_addr;
    logic             sram_wr_en, sram_rd_en;

    always #5 clk = ~clk;

    sram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_gnt       (wr_gnt),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_vld       (rd_vld),
        .rd_data      (rd_data),
        .sram_wr_en   (sram_wr_en),
        .sram_wr_addr (sram_wr_addr),
        .sram_din     (sram_din),
        .sram_rd_en   (sram_rd_en),
        .sram_rd_addr (sram_rd_addr),
        .sram_dout    (sram_dout)
    );

    // Physical SRAM: registered read, returns old data on a same-address collision.
    logic [DW-1:0] sram_mem [1<<AW];
    always @(posedge clk) begin
        if (sram_wr_en) sram_mem[sram_wr_addr] <= sram_din;
        if (sram_rd_en) sram_dout <= sram_mem[sram_rd_addr];
    end

    // Reference model state
    int            m_wr_ptr, m_rd_ptr;
    logic [DW-1:0] ref_mem [int];
    logic [NP-1:0] n_vld;
    logic [DW-1:0] n_data;
    bit            n_known;
    bit            hold, auto_mode;
    logic [NP-1:0] last_wgnt, last_rgnt;
    int            n_pass, n_total;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int rr_pick(input logic [NP-1:0] req, input int ptr);
        for (int i = 0; i < NP; i++) begin
            int j;
            j = (ptr + i) % NP;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_req[p]            = 1'b1;
        wr_addr[p*AW +: AW]  = a;
        wr_data[p*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_req[p]           = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    // One clock: check grants and SRAM drive, advance the model, check the response.
    task automatic step();
        int            w, r;
        logic [NP-1:0] ew, er;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        #1;
        w = -1; r = -1; ew = '0; er = '0; wa = '0; ra = '0; wd = '0;
        if (!rst) begin
            w = rr_pick(wr_req, m_wr_ptr);
            r = rr_pick(rd_req, m_rd_ptr);
        end
        if (w >= 0) begin ew[w] = 1'b1; wa = wr_addr[w*AW +: AW]; wd = wr_data[w*DW +: DW]; end
        if (r >= 0) begin er[r] = 1'b1; ra = rd_addr[r*AW +: AW]; end
        last_wgnt = wr_gnt;
        last_rgnt = rd_gnt;
        check("wr_gnt", 32'(wr_gnt), 32'(ew));
        check("rd_gnt", 32'(rd_gnt), 32'(er));
        check("sram_wr_en", 32'(sram_wr_en), (w >= 0) ? 1 : 0);
        check("sram_rd_en", 32'(sram_rd_en), (r >= 0) ? 1 : 0);
        if (w >= 0) begin
            check("sram_wr_addr", 32'(sram_wr_addr), 32'(wa));
            check("sram_din", 32'(sram_din), 32'(wd));
        end
        if (r >= 0) check("sram_rd_addr", 32'(sram_rd_addr), 32'(ra));
        if (rst) begin
            check("rd_vld_in_rst", 32'(rd_vld), 0);
            m_wr_ptr = 0; m_rd_ptr = 0; n_vld = '0; n_known = 1'b0;
        end else begin
            if (w >= 0) begin
                ref_mem[int'(wa)] = wd;
                m_wr_ptr = (w + 1) % NP;
            end
            n_vld   = er;
            n_known = 1'b0;
            if (r >= 0) begin
                m_rd_ptr = (r + 1) % NP;
                if (ref_mem.exists(int'(ra))) begin
                    n_known = 1'b1;
                    n_data  = ref_mem[int'(ra)];
                end
            end
        end
        @(posedge clk);
        #1;
        check("rd_vld", 32'(rd_vld), 32'(n_vld));
        if (n_vld != '0 && n_known) check("rd_data", 32'(rd_data), 32'(n_data));
        if (!hold) begin
            if (w >= 0) wr_req[w] = 1'b0;
            if (r >= 0) rd_req[r] = 1'b0;
        end
        if (auto_mode) begin
            for (int p = 0; p < NP; p++) begin
                if (!wr_req[p] && $urandom_range(0, 99) < 60)
                    set_wr(p, AW'($urandom_range(0, 15)), DW'($urandom));
                if (!rd_req[p] && $urandom_range(0, 99) < 60)
                    set_rd(p, AW'($urandom_range(0, 15)));
            end
        end
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        hold = 1'b0; auto_mode = 1'b0;
        m_wr_ptr = 0; m_rd_ptr = 0; n_vld = '0; n_known = 1'b0; n_data = '0;
        step(); step();
        rst = 1'b0;

        // 1: write then read, tagged response one cycle after grant
        set_wr(1, 14'h0010, 16'hBEEF); step();
        set_rd(2, 14'h0010); step();
        check("t1_rd_gnt", 32'(last_rgnt), 32'h4);
        check("t1_rd_vld", 32'(rd_vld), 32'h4);
        check("t1_rd_data", 32'(rd_data), 32'hBEEF);

        // 2: all writers held after reset rotate 0,1,2,3,0,...
        rst = 1'b1; step(); rst = 1'b0;
        hold = 1'b1;
        for (int p = 0; p < NP; p++) set_wr(p, AW'(32 + p), DW'(16'h0100 + p));
        for (int k = 0; k < 8; k++) begin
            step();
            check("t2_wr_gnt", 32'(last_wgnt), 32'(1 << (k % NP)));
        end
        hold = 1'b0; wr_req = '0;

        // 3: same-cycle read/write collision returns the new data
        set_wr(2, 14'h0005, 16'hAAAA); step();
        set_wr(0, 14'h0005, 16'h1234); set_rd(3, 14'h0005); step();
        check("t3_rd_vld", 32'(rd_vld), 32'h8);
        check("t3_rd_data", 32'(rd_data), 32'h1234);
        set_rd(1, 14'h0005); step();
        check("t3_reread", 32'(rd_data), 32'h1234);

        // 4: reset right after a read grant discards the response
        set_rd(0, 14'h0007); step();
        rst = 1'b1; step(); step();
        rst = 1'b0; step();
        check("t4_rd_vld_after", 32'(rd_vld), 0);

        // 5: lone port 3, then ports 0 and 3 together
        hold = 1'b1;
        set_rd(3, 14'h0001);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_solo_gnt", 32'(last_rgnt), 32'h8);
        end
        hold = 1'b0;
        set_rd(0, 14'h0002); step();
        check("t5_first_gnt", 32'(last_rgnt), 32'h1);
        step();
        check("t5_second_gnt", 32'(last_rgnt), 32'h8);

        // 6: top address and back-to-back reads
        set_wr(2, 14'h0000, 16'h5A5A); step();
        set_wr(1, 14'h3FFF, 16'hFFFF); step();
        set_rd(0, 14'h3FFF); set_rd(1, 14'h0000); step();
        check("t6_vld0", 32'(rd_vld), 32'h1);
        check("t6_data0", 32'(rd_data), 32'hFFFF);
        step();
        check("t6_vld1", 32'(rd_vld), 32'h2);
        check("t6_data1", 32'(rd_data), 32'h5A5A);

        // Randomized traffic on a small address range to provoke collisions
        auto_mode = 1'b1;
        for (int k = 0; k < 400; k++) step();
        auto_mode = 1'b0; wr_req = '0; rd_req = '0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
